// File: rtl/tia_hclock.sv
// tia_hclock: horizontal timing generator for the TIA model.
// Divides the color clock by four into non-overlapping two-phase strobes
// (hphi1 -> latch follow, hphi2 -> latch latch), runs the 57-state
// horizontal counter (228 color clocks per line) and decodes line_start,
// hsync and hblank, including the HMOVE-extended blank.
//
// All outputs are decoded purely from registered state, so nothing on the
// output side depends combinationally on rsync, hmove or reset.

module tia_hclock (
    input  logic       clock,
    input  logic       reset,
    input  logic       rsync,
    input  logic       hmove,
    output logic       hphi1,
    output logic       hphi2,
    output logic [5:0] hcount,
    output logic       line_start,
    output logic       hsync,
    output logic       hblank,
    output logic       hblank_ext
);

    // Line geometry: 57 counter states of four color clocks each.
    localparam logic [5:0] HCountLast    = 6'd56;
    localparam logic [5:0] HSyncFirst    = 6'd4;
    localparam logic [5:0] HSyncLast     = 6'd7;
    localparam logic [5:0] HBlankLast    = 6'd16;
    localparam logic [5:0] HBlankExtLast = 6'd18;

    // Phase 3 is the last color clock of a counter step; the pre-line state
    // (reset or rsync) parks here with the counter at its last value so that
    // the very next edge is a line wrap.
    localparam logic [1:0] PhaseLast     = 2'd3;

    logic [1:0] phase_q, phase_d;
    logic [5:0] hcount_q, hcount_d;
    logic       pend_q, pend_d;
    logic       ext_q, ext_d;

    logic       stepEdge;
    logic       wrapEdge;

    // A counter step happens on the edge leaving phase 3; a wrap is the step
    // that leaves the last counter value and begins a new line.
    assign stepEdge = (phase_q == PhaseLast);
    assign wrapEdge = stepEdge && (hcount_q == HCountLast);

    // Next-state logic: rsync forces the pre-line state while keeping any
    // pending HMOVE; otherwise advance phase/counter and manage the HMOVE
    // request so a strobe always targets the line after the one it lands in.
    always_comb begin
        phase_d  = phase_q;
        hcount_d = hcount_q;
        pend_d   = pend_q;
        ext_d    = ext_q;

        if (rsync) begin
            phase_d  = PhaseLast;
            hcount_d = HCountLast;
            pend_d   = pend_q | hmove;
        end else begin
            phase_d = phase_q + 2'd1;

            if (stepEdge) begin
                if (wrapEdge) begin
                    hcount_d = 6'd0;
                end else begin
                    hcount_d = hcount_q + 6'd1;
                end
            end

            if (wrapEdge) begin
                // The new line picks up what was pending; a strobe arriving
                // on this very edge is held for the line after it.
                ext_d  = pend_q;
                pend_d = hmove;
            end else if (hmove) begin
                pend_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset into the pre-line state.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= PhaseLast;
            hcount_q <= HCountLast;
            pend_q   <= 1'b0;
            ext_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            hcount_q <= hcount_d;
            pend_q   <= pend_d;
            ext_q    <= ext_d;
        end
    end

    // Output decodes; the pre-line state (hcount 56, phase 3) decodes to
    // all-zero strobes, sync and blank.
    always_comb begin
        hphi1      = (phase_q == 2'd0);
        hphi2      = (phase_q == 2'd2);
        hcount     = hcount_q;
        line_start = (phase_q == 2'd0) && (hcount_q == 6'd0);
        hsync      = (hcount_q >= HSyncFirst) && (hcount_q <= HSyncLast);
        hblank     = (hcount_q <= HBlankLast) ||
                     (ext_q && (hcount_q <= HBlankExtLast));
        hblank_ext = ext_q;
    end

endmodule

// File: tb/tb_tia_hclock.sv
// tb_tia_hclock: directed testbench for tia_hclock.
// Expected outputs are derived from the cycle position within a line
// (cycle 0 = line_start) and from which line should carry extended blank.

module tb_tia_hclock;

    logic       clock;
    logic       reset;
    logic       rsync;
    logic       hmove;
    logic       hphi1;
    logic       hphi2;
    logic [5:0] hcount;
    logic       line_start;
    logic       hsync;
    logic       hblank;
    logic       hblank_ext;

    int checks;
    int errors;

    tia_hclock dut (
        .clock      (clock),
        .reset      (reset),
        .rsync      (rsync),
        .hmove      (hmove),
        .hphi1      (hphi1),
        .hphi2      (hphi2),
        .hcount     (hcount),
        .line_start (line_start),
        .hsync      (hsync),
        .hblank     (hblank),
        .hblank_ext (hblank_ext)
    );

    // Free-running color clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one color clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Compare every output against the expected values for line cycle c.
    task automatic checkCycle(input int c, input bit extExp);
        int expBlank;
        expBlank = ((c <= 67) || (extExp && (c <= 75))) ? 1 : 0;
        checkOutput($sformatf("hcount c=%0d", c), int'(hcount), c / 4);
        checkOutput($sformatf("hphi1 c=%0d", c), int'(hphi1), (c % 4 == 0) ? 1 : 0);
        checkOutput($sformatf("hphi2 c=%0d", c), int'(hphi2), (c % 4 == 2) ? 1 : 0);
        checkOutput($sformatf("line_start c=%0d", c), int'(line_start), (c == 0) ? 1 : 0);
        checkOutput($sformatf("hsync c=%0d", c), int'(hsync), (c >= 16 && c <= 31) ? 1 : 0);
        checkOutput($sformatf("hblank c=%0d", c), int'(hblank), expBlank);
        checkOutput($sformatf("hblank_ext c=%0d", c), int'(hblank_ext), extExp ? 1 : 0);
    endtask

    // Pre-line state: counter parked at 56, strobes/sync/blank all low.
    task automatic checkPreLine(input string tag, input bit extExp);
        checkOutput({tag, " hcount"}, int'(hcount), 56);
        checkOutput({tag, " hphi1"}, int'(hphi1), 0);
        checkOutput({tag, " hphi2"}, int'(hphi2), 0);
        checkOutput({tag, " line_start"}, int'(line_start), 0);
        checkOutput({tag, " hsync"}, int'(hsync), 0);
        checkOutput({tag, " hblank"}, int'(hblank), 0);
        checkOutput({tag, " hblank_ext"}, int'(hblank_ext), extExp ? 1 : 0);
    endtask

    // Run one full line from cycle 0, optionally pulsing hmove at one cycle.
    task automatic runLine(input bit extExp, input int hmoveAt);
        for (int c = 0; c < 228; c++) begin
            checkCycle(c, extExp);
            hmove = (c == hmoveAt);
            applyStimulus();
            hmove = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        rsync  = 1'b0;
        hmove  = 1'b0;

        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkPreLine($sformatf("reset%0d", i), 1'b0);
        end

        // Release: first edge yields cycle 0, then two free-running lines.
        reset = 1'b0;
        applyStimulus();
        runLine(1'b0, -1);
        runLine(1'b0, -1);

        // HMOVE at cycle 100 extends only the following line.
        runLine(1'b0, 100);
        runLine(1'b1, -1);
        runLine(1'b0, -1);

        // HMOVE on the wrap edge skips one line.
        runLine(1'b0, 227);
        runLine(1'b0, -1);
        runLine(1'b1, -1);

        // RSYNC at cycle 50 with HMOVE pending from cycle 40.
        for (int c = 0; c <= 50; c++) begin
            checkCycle(c, 1'b0);
            hmove = (c == 40);
            rsync = (c == 50);
            applyStimulus();
            hmove = 1'b0;
            rsync = 1'b0;
        end
        checkPreLine("rsync", 1'b0);
        applyStimulus();
        runLine(1'b1, -1);

        // Reset at cycle 120 with HMOVE pending from cycle 110.
        for (int c = 0; c <= 120; c++) begin
            checkCycle(c, 1'b0);
            hmove = (c == 110);
            reset = (c == 120);
            applyStimulus();
            hmove = 1'b0;
        end
        checkPreLine("midreset", 1'b0);
        reset = 1'b0;
        applyStimulus();
        runLine(1'b0, -1);
        runLine(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
